// File: rtl/dfu_word_assembler.sv
// Byte-to-word packer feeding the dfu read FIFO, with CTS flow control toward the host.
// Optional partial-word idle discard is enabled by defining DFU_RX_TIMEOUT_EN.
module dfu_word_assembler #(
   parameter int DEPTH      = 16,
   parameter int CTS_MARGIN = 4,
   parameter int TIMEOUT    = 2000000
) (
   input  logic                     sysclk,
   input  logic                     sysrst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_strobe,
   input  logic                     dfu_rd_en,
   output logic [31:0]              dfu_dout,
   output logic                     dfu_valid,
   output logic                     dfu_empty,
   output logic                     CTS,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   word_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || CTS_MARGIN >= DEPTH || TIMEOUT < 1) begin : g_param_check
      $error("dfu_word_assembler: illegal parameter set");
   end

   logic [1:0]    idx_r;
   logic [23:0]   hold_r;
   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          push_s;
   logic          full_s;
   logic          pop_s;
   logic          wr_s;
   logic          tmo_s;

   assign push_s     = rx_strobe && (idx_r == 2'd3);
   assign full_s     = (count_r == CW'(DEPTH));
   assign pop_s      = dfu_rd_en && (count_r != {CW{1'b0}});
   assign wr_s       = push_s && !full_s;
   assign dfu_empty  = (count_r == {CW{1'b0}});
   assign word_count = count_r;

`ifdef DFU_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt_r;

   assign tmo_s = (idx_r != 2'd0) && !rx_strobe && (tmo_cnt_r == TW'(TIMEOUT - 1));

   // Idle-cycle counter, only running while a partial word is held
   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (rx_strobe || (idx_r == 2'd0) || tmo_s) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
   end
`else
   assign tmo_s = 1'b0;
`endif

   // Byte assembly: MSB-first into the holding register
   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         idx_r  <= 2'd0;
         hold_r <= 24'd0;
      end else if (rx_strobe) begin
         if (idx_r == 2'd3) begin
            idx_r <= 2'd0;
         end else begin
            idx_r <= idx_r + 2'd1;
            case (idx_r)
               2'd0:    hold_r[23:16] <= rx_data;
               2'd1:    hold_r[15:8]  <= rx_data;
               default: hold_r[7:0]   <= rx_data;
            endcase
         end
      end else if (tmo_s) begin
         idx_r  <= 2'd0;
         hold_r <= 24'd0;
      end else begin
         idx_r  <= idx_r;
         hold_r <= hold_r;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge sysclk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= {hold_r, rx_data};
      end
   end

   // Next occupancy from the accepted push and pop
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO pointers, count, read port and status flags
   always_ff @(posedge sysclk or negedge sysrst_n) begin
      if (!sysrst_n) begin
         wr_ptr_r  <= {AW{1'b0}};
         rd_ptr_r  <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         dfu_dout  <= 32'd0;
         dfu_valid <= 1'b0;
         CTS       <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
            dfu_dout <= mem_r[rd_ptr_r];
         end
         dfu_valid <= pop_s;
         // CTS lags count by one cycle; the margin covers bytes already in flight
         CTS <= ((CW'(DEPTH) - count_r) <= CW'(CTS_MARGIN));
         if (push_s && full_s) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dfu_word_assembler.sv
// Self-checking bench for dfu_word_assembler: directed scenarios plus random traffic
// checked against a queue-based reference model of bytes, words and flags.
module tb_dfu_word_assembler;

   localparam int DEPTH  = 16;
   localparam int MARGIN = 4;

   logic        sysclk = 1'b0;
   logic        sysrst_n = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_strobe = 1'b0;
   logic        dfu_rd_en = 1'b0;
   logic [31:0] dfu_dout;
   logic        dfu_valid;
   logic        dfu_empty;
   logic        CTS;
   logic        overflow;
   logic [4:0]  word_count;

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] mq[$];
   logic [7:0]  pend[$];
   logic [31:0] exp_dout;
   logic        exp_valid;
   logic        exp_cts;
   logic        exp_ovf;

   dfu_word_assembler #(.DEPTH(DEPTH), .CTS_MARGIN(MARGIN), .TIMEOUT(100)) dut (
      .sysclk(sysclk), .sysrst_n(sysrst_n), .rx_data(rx_data), .rx_strobe(rx_strobe),
      .dfu_rd_en(dfu_rd_en), .dfu_dout(dfu_dout), .dfu_valid(dfu_valid),
      .dfu_empty(dfu_empty), .CTS(CTS), .overflow(overflow), .word_count(word_count)
   );

   always #5 sysclk = ~sysclk;

   task automatic do_reset();
      @(negedge sysclk);
      sysrst_n = 1'b0; rx_strobe = 1'b0; dfu_rd_en = 1'b0; rx_data = 8'd0;
      mq.delete(); pend.delete();
      exp_dout = 32'd0; exp_valid = 1'b0; exp_cts = 1'b0; exp_ovf = 1'b0;
      repeat (2) @(negedge sysclk);
      sysrst_n = 1'b1;
   endtask

   // One clock: drive at negedge, update the model at posedge, return at next negedge.
   task automatic tick(input logic s, input logic [7:0] d, input logic r);
      int pre;
      logic [31:0] w;
      logic push;
      rx_strobe = s; rx_data = d; dfu_rd_en = r;
      @(posedge sysclk);
      pre = mq.size();
      push = 1'b0;
      w = 32'd0;
      if (s) begin
         pend.push_back(d);
         if (pend.size() == 4) begin
            w = {pend[0], pend[1], pend[2], pend[3]};
            pend.delete();
            push = 1'b1;
         end
      end
      exp_valid = 1'b0;
      if (r && pre != 0) begin
         exp_dout = mq.pop_front();
         exp_valid = 1'b1;
      end
      if (push) begin
         if (pre == DEPTH) exp_ovf = 1'b1;
         else mq.push_back(w);
      end
      exp_cts = ((DEPTH - pre) <= MARGIN);
      @(negedge sysclk);
      rx_strobe = 1'b0; dfu_rd_en = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic rd_last);
      tick(1'b1, w[31:24], 1'b0);
      tick(1'b1, w[23:16], 1'b0);
      tick(1'b1, w[15:8], 1'b0);
      tick(1'b1, w[7:0], rd_last);
   endtask

   task automatic test_reset();
      logic [4:0] cnt0;
      do_reset();
      n_cmp++; if (dfu_dout !== 32'd0) begin n_fail++; $display("FAIL rst_dout: got %h want 00000000", dfu_dout); end
      n_cmp++; if (dfu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", dfu_valid); end
      n_cmp++; if (dfu_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", dfu_empty); end
      n_cmp++; if (CTS !== 1'b0) begin n_fail++; $display("FAIL rst_cts: got %b want 0", CTS); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
      n_cmp++; if (word_count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", word_count); end
      // partial word then reset: stale bytes must not leak into the next word
      tick(1'b1, 8'h55, 1'b0);
      tick(1'b1, 8'h66, 1'b0);
      do_reset();
      send_word(32'h01234567, 1'b0);
      tick(1'b0, 8'd0, 1'b1);
      n_cmp++; if (dfu_dout !== 32'h01234567) begin n_fail++; $display("FAIL rst_partial: got %h want 01234567", dfu_dout); end
      // reset while dfu_valid is high
      send_word(32'h89ABCDEF, 1'b0);
      tick(1'b0, 8'd0, 1'b1);
      n_cmp++; if (dfu_valid !== 1'b1) begin n_fail++; $display("FAIL rst_midread_pre: got %b want 1", dfu_valid); end
      #1 sysrst_n = 1'b0;
      #1;
      cnt0 = word_count;
      n_cmp++; if (dfu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_midread_valid: got %b want 0", dfu_valid); end
      n_cmp++; if (cnt0 !== 5'd0) begin n_fail++; $display("FAIL rst_midread_count: got %0d want 0", cnt0); end
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      send_word(32'hDEADBEEF, 1'b0);
      n_cmp++; if (word_count !== 5'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", word_count); end
      n_cmp++; if (dfu_empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b want 0", dfu_empty); end
      tick(1'b0, 8'd0, 1'b1);
      n_cmp++; if (dfu_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", dfu_valid); end
      n_cmp++; if (dfu_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_dout: got %h want deadbeef", dfu_dout); end
      tick(1'b0, 8'd0, 1'b0);
      n_cmp++; if (dfu_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b want 0", dfu_valid); end
      n_cmp++; if (dfu_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after: got %b want 1", dfu_empty); end
      n_cmp++; if (dfu_dout !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_hold: got %h want deadbeef", dfu_dout); end
   endtask

   task automatic test_cts();
      do_reset();
      for (int i = 0; i < 11; i++) send_word($urandom, 1'b0);
      send_word($urandom, 1'b0);
      n_cmp++; if (CTS !== 1'b0) begin n_fail++; $display("FAIL cts_lag: got %b want 0", CTS); end
      tick(1'b0, 8'd0, 1'b0);
      n_cmp++; if (CTS !== 1'b1) begin n_fail++; $display("FAIL cts_set: got %b want 1", CTS); end
      tick(1'b0, 8'd0, 1'b1);
      n_cmp++; if (dfu_dout !== exp_dout) begin n_fail++; $display("FAIL cts_read: got %h want %h", dfu_dout, exp_dout); end
      n_cmp++; if (CTS !== 1'b1) begin n_fail++; $display("FAIL cts_hold: got %b want 1", CTS); end
      tick(1'b0, 8'd0, 1'b0);
      n_cmp++; if (CTS !== 1'b0) begin n_fail++; $display("FAIL cts_clear: got %b want 0", CTS); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) send_word(i, 1'b0);
      send_word(32'hFFFFFFFF, 1'b0);
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      n_cmp++; if (word_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", word_count); end
      for (int i = 0; i < 16; i++) begin
         tick(1'b0, 8'd0, 1'b1);
         n_cmp++;
         if (dfu_valid !== 1'b1 || dfu_dout !== 32'(i)) begin
            n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b %h want v=1 %h", i, dfu_valid, dfu_dout, 32'(i));
         end
      end
      tick(1'b0, 8'd0, 1'b1);
      n_cmp++; if (dfu_valid !== 1'b0 || dfu_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_extra: got v=%b e=%b want v=0 e=1", dfu_valid, dfu_empty); end
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 8'd0, 1'b1);
         n_cmp++;
         if (dfu_valid !== exp_valid || dfu_dout !== exp_dout) begin
            n_fail++; $display("FAIL b2b[%0d]: got v=%b %h want v=%b %h", i, dfu_valid, dfu_dout, exp_valid, exp_dout);
         end
         n_cmp++;
         if (dfu_valid !== (i < 5)) begin n_fail++; $display("FAIL b2b_pulse[%0d]: got %b want %b", i, dfu_valid, (i < 5)); end
      end
   endtask

   task automatic test_collide();
      do_reset();
      for (int i = 0; i < 16; i++) send_word(32'h100 + i, 1'b0);
      send_word(32'hCAFEF00D, 1'b1);
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL coll_full_ovf: got %b want 1", overflow); end
      n_cmp++; if (word_count !== 5'd15) begin n_fail++; $display("FAIL coll_full_count: got %0d want 15", word_count); end
      n_cmp++; if (dfu_dout !== 32'h100) begin n_fail++; $display("FAIL coll_full_dout: got %h want 00000100", dfu_dout); end
      do_reset();
      for (int i = 0; i < 8; i++) send_word(32'h200 + i, 1'b0);
      send_word(32'hCAFEF00D, 1'b1);
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL coll_mid_ovf: got %b want 0", overflow); end
      n_cmp++; if (word_count !== 5'd8) begin n_fail++; $display("FAIL coll_mid_count: got %0d want 8", word_count); end
      for (int i = 0; i < 8; i++) tick(1'b0, 8'd0, 1'b1);
      n_cmp++; if (dfu_dout !== 32'hCAFEF00D) begin n_fail++; $display("FAIL coll_mid_last: got %h want cafef00d", dfu_dout); end
   endtask

   task automatic test_partial();
      do_reset();
      tick(1'b1, 8'h11, 1'b0);
      tick(1'b1, 8'h22, 1'b0);
      repeat (100) tick(1'b0, 8'd0, 1'b0);
      tick(1'b1, 8'hAA, 1'b0);
      tick(1'b1, 8'hBB, 1'b0);
      tick(1'b1, 8'hCC, 1'b0);
      tick(1'b1, 8'hDD, 1'b0);
      tick(1'b0, 8'd0, 1'b1);
`ifdef DFU_RX_TIMEOUT_EN
      n_cmp++; if (dfu_dout !== 32'hAABBCCDD) begin n_fail++; $display("FAIL tmo_word: got %h want aabbccdd", dfu_dout); end
`else
      n_cmp++; if (dfu_dout !== 32'h1122AABB) begin n_fail++; $display("FAIL partial_word: got %h want 1122aabb", dfu_dout); end
      tick(1'b1, 8'hEE, 1'b0);
      tick(1'b1, 8'hFF, 1'b0);
      n_cmp++; if (word_count !== 5'd1) begin n_fail++; $display("FAIL partial_count: got %0d want 1", word_count); end
      tick(1'b0, 8'd0, 1'b1);
      n_cmp++; if (dfu_dout !== 32'hCCDDEEFF) begin n_fail++; $display("FAIL partial_rest: got %h want ccddeeff", dfu_dout); end
`endif
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0);
         n_cmp++;
         if (dfu_valid !== exp_valid || (exp_valid && dfu_dout !== exp_dout)) begin
            n_fail++; $display("FAIL rnd_read[%0d]: got v=%b %h want v=%b %h", i, dfu_valid, dfu_dout, exp_valid, exp_dout);
         end
         n_cmp++;
         if (word_count !== 5'(mq.size()) || dfu_empty !== (mq.size() == 0)) begin
            n_fail++; $display("FAIL rnd_count[%0d]: got %0d e=%b want %0d", i, word_count, dfu_empty, mq.size());
         end
         n_cmp++;
         if (CTS !== exp_cts || overflow !== exp_ovf) begin
            n_fail++; $display("FAIL rnd_flags[%0d]: got cts=%b ovf=%b want cts=%b ovf=%b", i, CTS, overflow, exp_cts, exp_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cts();
      test_overflow();
      test_back_to_back();
      test_collide();
      test_partial();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dfu_word_assembler.md
Name: dfu_word_assembler

Overview:
- Producer end of the data-from-USB (dfu) FIFO interface that core_16_top reads.
- Packs bytes from the UART receive path into 32-bit words, buffers them in an internal FIFO, and presents the dfu read side: dfu_empty, dfu_rd_en, dfu_dout, dfu_valid.
- Drives CTS so the host stops sending before the buffer overflows.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of two, 4..256.
- CTS_MARGIN, 4, CTS deasserts when free words <= CTS_MARGIN; must be less than DEPTH.
- TIMEOUT, 2000000, idle cycles after which a partial word is discarded. Used only with DFU_RX_TIMEOUT_EN.

Ports:
- sysclk  in  1  system clock, 200 MHz.
- sysrst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_strobe  in  1  one-cycle pulse; rx_data valid this cycle.
- dfu_rd_en  in  1  read request from core.
- dfu_dout  out  32  read data.
- dfu_valid  out  1  dfu_dout valid this cycle.
- dfu_empty  out  1  FIFO holds no complete word.
- CTS  out  1  active low; 0 = host may send.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- word_count  out  log2(DEPTH)+1  words currently stored.

Behaviour:
- Reset (sysrst_n=0, asynchronous):
  - Outputs: dfu_dout=0, dfu_valid=0, dfu_empty=1, CTS=0, overflow=0, word_count=0.
  - Byte index=0, shift register=0, FIFO pointers=0.
  - Reset mid-word discards the partial word. Reset mid-read drops the pending dfu_valid.
- Assembly: 2-bit byte index 0..3 plus a 24-bit holding register.
  - Byte order is MSB first: byte0 -> [31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
  - On rx_strobe with index<3: store the byte, index+1.
  - On rx_strobe with index=3: form the word {hold, rx_data}, issue a push, set index=0.
  - The push reaches the FIFO on the same edge; word_count updates on that edge.
- FIFO:
  - Binary read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a separate count register.
  - full = (count==DEPTH); dfu_empty = (count==0). Both derived from the registered count.
  - Push when full: word dropped, overflow set to 1 (cleared only by reset), pointers unchanged. This holds even if a read pops in the same cycle; full is evaluated on the pre-edge count.
  - Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Read handshake, one-cycle latency (standard FIFO read):
  - dfu_rd_en=1 and dfu_empty=0 at edge N: pop; dfu_dout=mem[rd_ptr] and dfu_valid=1 during cycle N+1.
  - dfu_rd_en=1 while dfu_empty=1: ignored, dfu_valid=0, no pointer change.
  - dfu_valid is a single-cycle pulse per pop. dfu_dout holds its last value when dfu_valid=0.
  - Back-to-back reads are allowed at one word per cycle.
- Flow control:
  - CTS=1 (stop) when DEPTH-count <= CTS_MARGIN; otherwise CTS=0.
  - CTS is registered: one cycle behind count.
  - The margin absorbs bytes already in flight from the host.
- word_count mirrors count.

Optional Feature:
- Macro: DFU_RX_TIMEOUT_EN.
- Defined:
  - A counter tracks idle cycles since the last rx_strobe while byte index != 0.
  - It clears on rx_strobe.
  - When it reaches TIMEOUT, index and holding register reset to 0 and the partial word is discarded; no push, no overflow.
  - The counter is idle while index=0.
- Not defined: a partial word waits indefinitely for the remaining bytes. No counter logic is present.

Test Plan:
- Reset, send bytes 0xDE,0xAD,0xBE,0xEF -> word_count=1, dfu_empty=0. Pulse dfu_rd_en -> next cycle dfu_valid=1, dfu_dout=0xDEADBEEF; afterwards dfu_empty=1.
- DEPTH=16, CTS_MARGIN=4: push 12 words with no reads -> CTS=1 one cycle after the 12th push. Read 1 word -> CTS=0 one cycle later.
- Push 16 words (values 0..15), then a 17th word (0xFFFFFFFF) -> overflow=1, word_count=16. Read all 16 -> values 0..15 in order, no 0xFFFFFFFF.
- Hold dfu_rd_en=1 continuously over 5 stored words -> 5 consecutive dfu_valid pulses with correct data. dfu_rd_en held while empty -> dfu_valid stays 0.
- Count=16 and a read coincide with the 4th byte strobe -> new word dropped, overflow=1, count=15. Same event at count=8 -> count stays 8, word stored.
- With DFU_RX_TIMEOUT_EN, TIMEOUT=100: send 0x11,0x22, idle 100 cycles, then send 0xAA,0xBB,0xCC,0xDD -> single word 0xAABBCCDD. Without the macro -> word 0x1122AABB, 0xCC,0xDD pending.
